// File: rtl/spi_master.sv
// SPI mode-0 (CPOL=0, CPHA=0) MSB-first master with chip-select setup, hold
// and idle timing. Supports single transfers and back-to-back bursts that
// keep ss low.
module spi_master #(
  parameter int unsigned DATA_W   = 8,
  parameter int unsigned HALF_DIV = 3,
  parameter int unsigned CS_SETUP = 2,
  parameter int unsigned CS_HOLD  = 2,
  parameter int unsigned CS_IDLE  = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [DATA_W-1:0] din,
  input  logic              keep_ss,
  output logic              ready,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] dout,
  output logic              sck,
  output logic              ss,
  output logic              mosi,
  input  logic              miso
);

  localparam int unsigned MaxAB    = (HALF_DIV > CS_SETUP) ? HALF_DIV : CS_SETUP;
  localparam int unsigned MaxCD    = (CS_HOLD > CS_IDLE) ? CS_HOLD : CS_IDLE;
  localparam int unsigned CntMax   = (MaxAB > MaxCD) ? MaxAB : MaxCD;
  localparam int unsigned CntW     = $clog2(CntMax + 1);
  localparam int unsigned HalfW    = $clog2(2 * DATA_W + 1);
  localparam int unsigned LastHalf = 2 * DATA_W - 1;

  typedef enum logic [2:0] {StIdle, StSetup, StShift, StHold, StGap, StLinger} state_e;

  state_e              state_q, state_d;
  logic [CntW-1:0]     cnt_q, cnt_d;
  logic [HalfW-1:0]    half_q, half_d;
  logic [DATA_W-1:0]   tx_q, tx_d;
  logic [DATA_W-1:0]   rx_q, rx_d;
  logic [DATA_W-1:0]   dout_q, dout_d;
  logic                sck_q, sck_d;
  logic                mosi_q, mosi_d;
  logic                done_q, done_d;
  logic                ss_q, ss_d;
  logic                busy_q, busy_d;
  logic                ready_q, ready_d;

  // State register: reset parks in GAP so ss stays high for a full idle period.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StGap;
      cnt_q   <= '0;
      half_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      half_q  <= half_d;
    end
  end

  // Next-state and datapath: timing counters, sck toggling, shift registers.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    half_d  = half_q;
    sck_d   = sck_q;
    tx_d    = tx_q;
    rx_d    = rx_q;
    mosi_d  = mosi_q;
    dout_d  = dout_q;
    done_d  = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (start && ready_q) begin
          tx_d    = din;
          mosi_d  = din[DATA_W-1];
          cnt_d   = '0;
          state_d = StSetup;
        end
      end
      StSetup: begin
        if (cnt_q == CntW'(CS_SETUP - 1)) begin
          cnt_d   = '0;
          half_d  = '0;
          sck_d   = 1'b0;
          state_d = StShift;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StShift: begin
        if (cnt_q == CntW'(HALF_DIV - 1)) begin
          cnt_d  = '0;
          half_d = half_q + 1'b1;
          sck_d  = ~sck_q;
          if (!sck_q) begin
            // Rising sck edge: capture miso.
            rx_d = {rx_q[DATA_W-2:0], miso};
          end else if (half_q == HalfW'(LastHalf)) begin
            // Final falling edge: publish the received word.
            dout_d  = rx_q;
            done_d  = 1'b1;
            half_d  = '0;
            state_d = keep_ss ? StLinger : StHold;
          end else begin
            tx_d   = tx_q << 1;
            mosi_d = tx_d[DATA_W-1];
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StHold: begin
        if (cnt_q == CntW'(CS_HOLD - 1)) begin
          cnt_d   = '0;
          state_d = StGap;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StGap: begin
        if (cnt_q == CntW'(CS_IDLE - 1)) begin
          cnt_d   = '0;
          state_d = StIdle;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StLinger: begin
        // A new start wins over keep_ss dropping in the same cycle.
        if (start && ready_q) begin
          tx_d    = din;
          mosi_d  = din[DATA_W-1];
          cnt_d   = '0;
          half_d  = '0;
          state_d = StShift;
        end else if (!keep_ss) begin
          cnt_d   = '0;
          state_d = StHold;
        end
      end
      default: begin
        cnt_d   = '0;
        state_d = StGap;
      end
    endcase
  end

  // Output decode from the next state so ss/busy/ready are registered with it.
  always_comb begin
    ss_d    = 1'b1;
    busy_d  = 1'b0;
    ready_d = 1'b0;
    unique case (state_d)
      StIdle:                   ready_d = 1'b1;
      StSetup, StShift, StHold: begin
        ss_d   = 1'b0;
        busy_d = 1'b1;
      end
      StLinger: begin
        ss_d    = 1'b0;
        // ready rises one cycle after done, so a start coinciding with done is dropped.
        ready_d = (state_q == StLinger);
      end
      default: ;
    endcase
  end

  // Output and datapath registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      tx_q    <= '0;
      rx_q    <= '0;
      dout_q  <= '0;
      sck_q   <= 1'b0;
      mosi_q  <= 1'b0;
      done_q  <= 1'b0;
      ss_q    <= 1'b1;
      busy_q  <= 1'b0;
      ready_q <= 1'b0;
    end else begin
      tx_q    <= tx_d;
      rx_q    <= rx_d;
      dout_q  <= dout_d;
      sck_q   <= sck_d;
      mosi_q  <= mosi_d;
      done_q  <= done_d;
      ss_q    <= ss_d;
      busy_q  <= busy_d;
      ready_q <= ready_d;
    end
  end

  assign ready = ready_q;
  assign busy  = busy_q;
  assign done  = done_q;
  assign dout  = dout_q;
  assign sck   = sck_q;
  assign ss    = ss_q;
  assign mosi  = mosi_q;

endmodule

// File: tb/tb_spi_master.sv
// Self-checking bench for spi_master: loopback and slave-model transfers,
// bursts, ignored starts, and reset behaviour.
module tb_spi_master;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic [7:0] din = 8'h00;
  logic       keep_ss = 1'b0;
  logic       ready, busy, done, sck, ss, mosi, miso;
  logic [7:0] dout;

  // miso source: loopback or a slave that shifts slv_tx out MSB first.
  logic       loop_mode = 1'b1;
  logic [7:0] slv_tx = 8'h00;
  assign miso = loop_mode ? mosi : slv_tx[7];

  int checks = 0;
  int failures = 0;
  logic [7:0] exp_q[$];

  spi_master dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .din     (din),
    .keep_ss (keep_ss),
    .ready   (ready),
    .busy    (busy),
    .done    (done),
    .dout    (dout),
    .sck     (sck),
    .ss      (ss),
    .mosi    (mosi),
    .miso    (miso)
  );

  always #5 clk = ~clk;

  // Edge counter, updated at the edge itself.
  int unsigned edge_n = 0;
  always @(posedge clk) edge_n = edge_n + 1;

  // Bus monitor at #1 after each edge; tasks read its results at #2.
  int unsigned rise_cnt = 0;
  int unsigned done_cnt = 0;
  int unsigned ss_rise_cnt = 0;
  int unsigned sck_ss_bad = 0;
  int unsigned last_fall_e = 0;
  int unsigned ss_rise_e = 0;
  int unsigned rise_e[$];
  logic [7:0]  mosi_cap = 8'h00;
  logic        sck_p, ss_p;

  always @(posedge clk) begin
    #1;
    if (sck === 1'b1 && sck_p === 1'b0) begin
      rise_cnt = rise_cnt + 1;
      rise_e.push_back(edge_n);
      mosi_cap = {mosi_cap[6:0], mosi};
    end
    if (sck === 1'b0 && sck_p === 1'b1) begin
      last_fall_e = edge_n;
      slv_tx = {slv_tx[6:0], 1'b0};
    end
    if (done === 1'b1) done_cnt = done_cnt + 1;
    if (ss === 1'b1 && ss_p === 1'b0) begin
      ss_rise_cnt = ss_rise_cnt + 1;
      ss_rise_e = edge_n;
    end
    if (sck === 1'b1 && ss === 1'b1) sck_ss_bad = sck_ss_bad + 1;
    sck_p = sck;
    ss_p  = ss;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // Wait for ready, present one start pulse; acc is the accepting edge.
  task automatic kick(input logic [7:0] d, input logic k, output int unsigned acc,
                      output bit ok);
    int n = 0;
    while (ready !== 1'b1 && n < 100) begin
      @(posedge clk); #2;
      n++;
    end
    ok = (n < 100);
    din = d;
    keep_ss = k;
    start = 1'b1;
    @(posedge clk); #2;
    acc = edge_n;
    start = 1'b0;
  endtask

  task automatic wait_done(output bit ok);
    int n = 0;
    while (done !== 1'b1 && n < 400) begin
      @(posedge clk); #2;
      n++;
    end
    ok = (done === 1'b1);
  endtask

  task automatic wait_ss_high(output bit ok);
    int n = 0;
    while (ss !== 1'b1 && n < 50) begin
      @(posedge clk); #2;
      n++;
    end
    ok = (ss === 1'b1);
  endtask

  task automatic clear_mon();
    rise_cnt = 0;
    rise_e.delete();
    mosi_cap = 8'h00;
    done_cnt = 0;
  endtask

  task automatic test_reset_initial();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #2;
    rst = 1'b0;
    checks++; if (ss !== 1'b1) begin failures++; $display("FAIL por_ss: got %b want 1", ss); end
    checks++; if (sck !== 1'b0) begin failures++; $display("FAIL por_sck: got %b want 0", sck); end
    checks++; if (ready !== 1'b0) begin failures++; $display("FAIL por_ready: got %b want 0", ready); end
    checks++; if (dout !== 8'h00) begin failures++; $display("FAIL por_dout: got %h want 00", dout); end
    for (int i = 1; i <= 4; i++) begin
      @(posedge clk); #2;
      checks++;
      if (ready !== (i == 4)) begin
        failures++;
        $display("FAIL por_ready_rise cycle %0d: got %b want %b", i, ready, (i == 4));
      end
    end
  endtask

  task automatic test_loopback();
    int unsigned acc;
    int unsigned bad_period = 0;
    bit ok;
    logic [7:0] exp;
    loop_mode = 1'b1;
    clear_mon();
    exp_q.push_back(8'h18);
    kick(8'h18, 1'b0, acc, ok);
    checks++; if (!ok) begin failures++; $display("FAIL lb_ready: got timeout want ready"); end
    wait_done(ok);
    checks++; if (!ok) begin failures++; $display("FAIL lb_done: got timeout want done"); end
    checks++;
    if (edge_n - acc != 50) begin
      failures++;
      $display("FAIL lb_latency: got %0d want 50 edges after accept", edge_n - acc);
    end
    exp = exp_q.pop_front();
    checks++; if (dout !== exp) begin failures++; $display("FAIL lb_dout: got %h want %h", dout, exp); end
    checks++;
    if (mosi_cap !== 8'h18) begin failures++; $display("FAIL lb_mosi: got %h want 18", mosi_cap); end
    checks++;
    if (rise_cnt != 8) begin failures++; $display("FAIL lb_pulses: got %0d want 8", rise_cnt); end
    checks++;
    if (rise_e.size() > 0 && rise_e[0] - acc != 5) begin
      failures++;
      $display("FAIL lb_first_rise: got %0d want 5", rise_e[0] - acc);
    end
    for (int i = 1; i < rise_e.size(); i++) if (rise_e[i] - rise_e[i-1] != 6) bad_period++;
    checks++;
    if (bad_period != 0) begin
      failures++;
      $display("FAIL lb_period: got %0d bad intervals want 0", bad_period);
    end
    wait_ss_high(ok);
    checks++;
    if (!ok || ss_rise_e - last_fall_e != 2) begin
      failures++;
      $display("FAIL lb_cs_hold: got %0d want 2", ss_rise_e - last_fall_e);
    end
    repeat (5) @(posedge clk);
    #2;
    checks++;
    if (done_cnt != 1) begin failures++; $display("FAIL lb_done_count: got %0d want 1", done_cnt); end
  endtask

  task automatic test_reset_mid_shift();
    int unsigned acc;
    int unsigned dc;
    bit ok;
    loop_mode = 1'b1;
    kick(8'hC3, 1'b0, acc, ok);
    repeat (20) @(posedge clk);
    #2;
    checks++; if (busy !== 1'b1) begin failures++; $display("FAIL rs_busy_pre: got %b want 1", busy); end
    dc = done_cnt;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #2;
    rst = 1'b0;
    checks++; if (ss !== 1'b1) begin failures++; $display("FAIL rs_ss: got %b want 1", ss); end
    checks++; if (sck !== 1'b0) begin failures++; $display("FAIL rs_sck: got %b want 0", sck); end
    checks++; if (mosi !== 1'b0) begin failures++; $display("FAIL rs_mosi: got %b want 0", mosi); end
    checks++; if (done !== 1'b0) begin failures++; $display("FAIL rs_done: got %b want 0", done); end
    checks++; if (dout !== 8'h00) begin failures++; $display("FAIL rs_dout: got %h want 00", dout); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL rs_busy: got %b want 0", busy); end
    for (int i = 1; i <= 4; i++) begin
      @(posedge clk); #2;
      checks++;
      if (ready !== (i == 4)) begin
        failures++;
        $display("FAIL rs_ready cycle %0d: got %b want %b", i, ready, (i == 4));
      end
    end
    repeat (40) @(posedge clk);
    #2;
    checks++;
    if (done_cnt != dc) begin failures++; $display("FAIL rs_no_done: got %0d want %0d", done_cnt, dc); end
  endtask

  task automatic test_slave();
    int unsigned acc;
    bit ok;
    logic [7:0] exp;
    clear_mon();
    loop_mode = 1'b0;
    slv_tx = 8'hA5;
    exp_q.push_back(8'hA5);
    kick(8'h3C, 1'b0, acc, ok);
    wait_done(ok);
    checks++; if (!ok) begin failures++; $display("FAIL sl_done: got timeout want done"); end
    exp = exp_q.pop_front();
    checks++; if (dout !== exp) begin failures++; $display("FAIL sl_dout: got %h want %h", dout, exp); end
    checks++;
    if (mosi_cap !== 8'h3C) begin failures++; $display("FAIL sl_mosi: got %h want 3c", mosi_cap); end
    wait_ss_high(ok);
    loop_mode = 1'b1;
  endtask

  task automatic test_burst();
    int unsigned acc1, acc2, r8;
    int unsigned sr0;
    bit ok;
    logic [7:0] exp;
    loop_mode = 1'b1;
    clear_mon();
    sr0 = ss_rise_cnt;
    exp_q.push_back(8'h12);
    kick(8'h12, 1'b1, acc1, ok);
    wait_done(ok);
    exp = exp_q.pop_front();
    checks++; if (dout !== exp) begin failures++; $display("FAIL bu_dout1: got %h want %h", dout, exp); end
    checks++;
    if (ready !== 1'b0) begin failures++; $display("FAIL bu_ready_at_done: got %b want 0", ready); end
    exp_q.push_back(8'h34);
    kick(8'h34, 1'b0, acc2, ok);
    checks++; if (!ok) begin failures++; $display("FAIL bu_ready: got timeout want ready"); end
    wait_done(ok);
    exp = exp_q.pop_front();
    checks++; if (dout !== exp) begin failures++; $display("FAIL bu_dout2: got %h want %h", dout, exp); end
    checks++;
    if (ss_rise_cnt != sr0) begin
      failures++;
      $display("FAIL bu_ss_low: got %0d ss rises want 0", ss_rise_cnt - sr0);
    end
    checks++;
    if (rise_cnt != 16) begin failures++; $display("FAIL bu_pulses: got %0d want 16", rise_cnt); end
    r8 = (rise_e.size() > 8) ? rise_e[8] : 0;
    checks++;
    if (r8 - acc2 != 3) begin failures++; $display("FAIL bu_no_setup: got %0d want 3", r8 - acc2); end
    checks++;
    if (done_cnt != 2) begin failures++; $display("FAIL bu_done_count: got %0d want 2", done_cnt); end
    wait_ss_high(ok);
  endtask

  task automatic test_ignored();
    int unsigned acc, acc2;
    bit ok;
    logic [7:0] exp;
    loop_mode = 1'b1;
    clear_mon();
    exp_q.push_back(8'h5A);
    kick(8'h5A, 1'b0, acc, ok);
    repeat (20) @(posedge clk);
    #2;
    din = 8'hEE;
    start = 1'b1;
    @(posedge clk); #2;
    start = 1'b0;
    wait_done(ok);
    exp = exp_q.pop_front();
    checks++; if (dout !== exp) begin failures++; $display("FAIL ig_dout: got %h want %h", dout, exp); end
    wait_ss_high(ok);
    start = 1'b1;
    @(posedge clk); #2;
    start = 1'b0;
    repeat (2) @(posedge clk);
    #2;
    checks++;
    if (ss !== 1'b1) begin failures++; $display("FAIL ig_gap_start: got ss=%b want 1", ss); end
    checks++;
    if (rise_cnt != 8) begin failures++; $display("FAIL ig_pulses: got %0d want 8", rise_cnt); end
    exp_q.push_back(8'h66);
    kick(8'h66, 1'b0, acc2, ok);
    checks++;
    if (acc2 - ss_rise_e < 4) begin
      failures++;
      $display("FAIL ig_cs_idle: got %0d want >=4", acc2 - ss_rise_e);
    end
    wait_done(ok);
    exp = exp_q.pop_front();
    checks++; if (dout !== exp) begin failures++; $display("FAIL ig_dout2: got %h want %h", dout, exp); end
    checks++;
    if (done_cnt != 2) begin failures++; $display("FAIL ig_done_count: got %0d want 2", done_cnt); end
    wait_ss_high(ok);
  endtask

  task automatic test_abort();
    int unsigned acc;
    int unsigned dc;
    int n = 0;
    bit ok;
    logic [7:0] exp;
    loop_mode = 1'b1;
    clear_mon();
    kick(8'hFF, 1'b0, acc, ok);
    while (rise_cnt < 3 && n < 100) begin
      @(posedge clk); #2;
      n++;
    end
    checks++;
    if (rise_cnt != 3) begin failures++; $display("FAIL ab_third_rise: got %0d want 3", rise_cnt); end
    dc = done_cnt;
    rst = 1'b1;
    @(posedge clk); #2;
    rst = 1'b0;
    checks++; if (sck !== 1'b0) begin failures++; $display("FAIL ab_sck: got %b want 0", sck); end
    repeat (60) @(posedge clk);
    #2;
    checks++;
    if (done_cnt != dc) begin failures++; $display("FAIL ab_no_done: got %0d want %0d", done_cnt, dc); end
    clear_mon();
    exp_q.push_back(8'h81);
    kick(8'h81, 1'b0, acc, ok);
    wait_done(ok);
    exp = exp_q.pop_front();
    checks++; if (dout !== exp) begin failures++; $display("FAIL ab_dout: got %h want %h", dout, exp); end
    checks++;
    if (rise_cnt != 8) begin failures++; $display("FAIL ab_pulses: got %0d want 8", rise_cnt); end
    checks++;
    if (mosi_cap !== 8'h81) begin failures++; $display("FAIL ab_mosi: got %h want 81", mosi_cap); end
    wait_ss_high(ok);
  endtask

  task automatic test_invariants();
    checks++;
    if (sck_ss_bad != 0) begin
      failures++;
      $display("FAIL sck_with_ss_high: got %0d cycles want 0", sck_ss_bad);
    end
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_empty: got %0d left want 0", exp_q.size());
    end
  endtask

  initial begin
    test_reset_initial();
    test_loopback();
    test_reset_mid_shift();
    test_slave();
    test_burst();
    test_ignored();
    test_abort();
    test_invariants();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
